// File: rtl/fib_job_scheduler.sv
// Two-requester Fibonacci job scheduler around one shared a/b step datapath.
// Jobs are granted round-robin and run to completion, one step per cycle.
//
// state  | meaning
// S_IDLE | waiting for a request; grants one requester
// S_RUN  | stepping a<=b, b<=a+b until the step count is exhausted
// S_RESP | presenting the result to the owning requester
module fib_job_scheduler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [CNT_W-1:0] i_req0_n,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [CNT_W-1:0] i_req1_n,
  output logic             o_resp0_valid,
  input  logic             i_resp0_ready,
  output logic             o_resp1_valid,
  input  logic             i_resp1_ready,
  output logic [WIDTH-1:0] o_resp_data,
  output logic             o_resp_ovf,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_a;
  logic             r_ovf_b;
  logic             r_owner;
  logic             r_last_grant;

  logic             w_grant;
  logic             w_accept;
  logic             w_resp_take;
  logic [CNT_W-1:0] w_n;
  logic [WIDTH:0]   w_sum;

  // On a tie the requester that was not served last wins.
  assign w_grant     = (i_req0_valid & i_req1_valid) ? ~r_last_grant : i_req1_valid;
  assign w_accept    = (r_state == S_IDLE) & (i_req0_valid | i_req1_valid);
  assign w_n         = w_grant ? i_req1_n : i_req0_n;
  assign w_resp_take = (r_state == S_RESP) & (r_owner ? i_resp1_ready : i_resp0_ready);
  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_req0_ready  = 1'b0;
    o_req1_ready  = 1'b0;
    o_resp0_valid = 1'b0;
    o_resp1_valid = 1'b0;
    o_resp_data   = '0;
    o_resp_ovf    = 1'b0;
    o_busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_n == '0) ? S_RESP : S_RUN;
        end
        o_req0_ready = ~rst & w_accept & ~w_grant;
        o_req1_ready = ~rst & w_accept & w_grant;
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_RESP;
        end
        o_busy = ~rst;
      end
      S_RESP: begin
        if (w_resp_take) begin
          w_state_nxt = S_IDLE;
        end
        o_busy        = ~rst;
        o_resp0_valid = ~rst & ~r_owner;
        o_resp1_valid = ~rst & r_owner;
        o_resp_data   = rst ? '0 : r_a;
        o_resp_ovf    = ~rst & r_ovf_a;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= WIDTH'(1);
      r_cnt        <= '0;
      r_ovf_a      <= 1'b0;
      r_ovf_b      <= 1'b0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= '0;
            r_b     <= WIDTH'(1);
            r_cnt   <= w_n;
            r_ovf_a <= 1'b0;
            r_ovf_b <= 1'b0;
            r_owner <= w_grant;
          end
        end
        S_RUN: begin
          // ovf flags follow their registers, so b overflowing alone never flags a.
          r_a     <= r_b;
          r_b     <= w_sum[WIDTH-1:0];
          r_cnt   <= r_cnt - CNT_W'(1);
          r_ovf_a <= r_ovf_b;
          r_ovf_b <= r_ovf_a | r_ovf_b | w_sum[WIDTH];
        end
        S_RESP: begin
          if (w_resp_take) begin
            r_last_grant <= r_owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_job_scheduler.sv
// Self-checking bench for fib_job_scheduler: directed boundary/protocol steps,
// then randomized jobs checked against an arithmetic Fibonacci reference.
module tb_fib_job_scheduler;
  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          v0, v1, rr0, rr1;
  logic [CW-1:0] n0, n1;
  logic          rdy0, rdy1, rv0, rv1, rovf, busy;
  logic [W-1:0]  rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int lastg    = 1;

  fib_job_scheduler #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_n(n0),
    .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_n(n1),
    .o_resp0_valid(rv0), .i_resp0_ready(rr0),
    .o_resp1_valid(rv1), .i_resp1_ready(rr1),
    .o_resp_data(rdata), .o_resp_ovf(rovf), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // True F(n) saturated far above 2^W for the overflow flag; data kept mod 2^W.
  function automatic logic [W:0] ref_fib(input int n);
    longint t0 = 0, t1 = 1, t;
    int m0 = 0, m1 = 1, m;
    for (int i = 0; i < n; i++) begin
      t  = t0 + t1;
      t0 = t1;
      t1 = (t > 64'd1099511627776) ? 64'd1099511627776 : t;
      m  = (m0 + m1) % 256;
      m0 = m1;
      m1 = m;
    end
    return {(t0 >= 256) ? 1'b1 : 1'b0, 8'(m0)};
  endfunction

  function automatic logic rdy(input int id);
    return (id != 0) ? rdy1 : rdy0;
  endfunction

  function automatic logic rvld(input int id);
    return (id != 0) ? rv1 : rv0;
  endfunction

  task automatic set_req(input int id, input logic v, input int n);
    if (id != 0) begin v1 = v; n1 = CW'(n); end
    else begin v0 = v; n0 = CW'(n); end
  endtask

  task automatic set_rr(input int id, input logic v);
    if (id != 0) rr1 = v;
    else rr0 = v;
  endtask

  task automatic accept(input int id, input int n);
    int k = 0;
    set_req(id, 1'b1, n);
    #1;
    while (!rdy(id) && k < 20) begin
      @(negedge clk); #1; k++;
    end
    chk("accept_ready", rdy(id), 1);
    chk("single_ready", rdy(1 - id), 0);
    @(negedge clk);
    set_req(id, 1'b0, $urandom_range(0, 255));
    #1;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic collect(input int id, input int n, input int hold, input bit wrong);
    logic [W:0] e;
    int k = 0;
    e = ref_fib(n);
    while (!rvld(id) && k < n + 4) begin
      @(negedge clk); #1; k++;
    end
    chk("latency", k, n);
    chk("resp_data", rdata, e[W-1:0]);
    chk("resp_ovf", rovf, e[W]);
    chk("other_resp_valid", rvld(1 - id), 0);
    for (int h = 0; h < hold; h++) begin
      if (wrong) set_rr(1 - id, 1'b1);
      @(negedge clk); #1;
      chk("hold_valid", rvld(id), 1);
      chk("hold_data", rdata, e[W-1:0]);
      chk("hold_ovf", rovf, e[W]);
      chk("hold_no_ready", {rdy0, rdy1}, 0);
    end
    set_rr(1 - id, 1'b0);
    set_rr(id, 1'b1);
    @(negedge clk); #1;
    set_rr(id, 1'b0);
    chk("idle_after_resp", busy, 0);
    chk("resp_dropped", rvld(id), 0);
    lastg = id;
  endtask

  initial begin
    int g, ng, hold;
    bit wrong;
    rst = 1'b1; rr0 = 1'b0; rr1 = 1'b0;
    v0 = 1'b1; n0 = 8'd5; v1 = 1'b1; n1 = 8'd6;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {rdy0, rdy1, rv0, rv1, rdata, rovf, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    lastg = 1;

    // both valid from reset: 0 first, then 1, then 0 again
    accept(0, 5);
    collect(0, 5, 0, 1'b0);
    set_req(0, 1'b1, 5);
    #1;
    chk("alternate_to_1", rdy1, 1);
    chk("alternate_not_0", rdy0, 0);
    accept(1, 6);
    collect(1, 6, 0, 1'b0);
    accept(0, 5);
    collect(0, 5, 0, 1'b0);

    accept(0, 10);  collect(0, 10, 0, 1'b0);
    accept(0, 0);   collect(0, 0, 0, 1'b0);
    accept(1, 1);   collect(1, 1, 0, 1'b0);
    accept(0, 13);  collect(0, 13, 0, 1'b0);
    accept(1, 14);  collect(1, 14, 0, 1'b0);
    accept(0, 255); collect(0, 255, 0, 1'b0);

    // backpressure with a competing request pending
    accept(0, 7);
    set_req(1, 1'b1, 2);
    collect(0, 7, 5, 1'b0);
    chk("idle_grants_waiting", rdy1, 1);
    set_req(1, 1'b0, 2);

    // owner 1 in RESP ignores resp0_ready
    accept(1, 3);
    collect(1, 3, 3, 1'b1);

    // reset three cycles into a job
    accept(0, 10);
    repeat (2) @(negedge clk);
    set_req(0, 1'b1, 4);
    set_req(1, 1'b1, 4);
    rst = 1'b1;
    #1;
    chk("rst_midrun_outputs", {rdy0, rdy1, rv0, rv1, rdata, rovf, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    lastg = 1;
    #1;
    chk("post_rst_grant0", rdy0, 1);
    chk("post_rst_no_grant1", rdy1, 0);
    chk("post_rst_no_resp", {rv0, rv1}, 0);
    accept(0, 4); collect(0, 4, 0, 1'b0);
    accept(1, 4); collect(1, 4, 0, 1'b0);

    for (int it = 0; it < 24; it++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      n0 = CW'($urandom_range(0, 30));
      n1 = CW'($urandom_range(0, 30));
      #1;
      g  = (v0 && v1) ? 1 - lastg : (v1 ? 1 : 0);
      ng = (g != 0) ? int'(n1) : int'(n0);
      chk("rand_grant0", rdy0, (g == 0) ? 1 : 0);
      chk("rand_grant1", rdy1, (g == 1) ? 1 : 0);
      @(negedge clk);
      v0 = 1'b0; v1 = 1'b0;
      n0 = CW'($urandom_range(0, 255));
      n1 = CW'($urandom_range(0, 255));
      hold  = $urandom_range(0, 3);
      wrong = 1'($urandom_range(0, 1));
      #1;
      collect(g, ng, hold, wrong);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_job_scheduler.md
Name: fib_job_scheduler

Overview:
- Shared iterative Fibonacci engine with one 2-register (a,b) add/shift datapath: a<=b, b<=a+b, wrapping at WIDTH bits.
- Two requesters time-share the engine. Each job computes F(n) and returns a WIDTH-bit result plus an overflow flag.
- Jobs are granted round-robin and run to completion one at a time, one step per cycle.
- Sits between client logic and the Fibonacci step datapath; it owns the sequencing, the step counter and the arbitration state.

Parameters:
- WIDTH, 8, data width of a, b and the result.
- CNT_W, 8, width of the job step count n.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid  input  1  requester 0 has a job.
- req0_ready  output  1  engine accepts requester 0's job this cycle.
- req0_n  input  CNT_W  requester 0 step count n.
- req1_valid  input  1  requester 1 has a job.
- req1_ready  output  1  engine accepts requester 1's job this cycle.
- req1_n  input  CNT_W  requester 1 step count n.
- resp0_valid  output  1  result for requester 0 available.
- resp0_ready  input  1  requester 0 takes the result.
- resp1_valid  output  1  result for requester 1 available.
- resp1_ready  input  1  requester 1 takes the result.
- resp_data  output  WIDTH  F(n) mod 2^WIDTH; valid only with resp0_valid or resp1_valid.
- resp_ovf  output  1  1 if true F(n) >= 2^WIDTH.
- busy  output  1  state != IDLE.

Behaviour:
- Reset: clk and rst as already decided — reset rst, asynchronous, active-high; clock clk. rst asserted at any time, including mid-RUN or mid-RESP:
  - state=IDLE; a=0, b=1, cnt=0; ovf_a=ovf_b=0; owner=0; last_grant=1, so requester 0 wins the first tie.
  - The in-flight job is dropped with no response.
  - All outputs are 0 while rst is high: req*_ready, resp*_valid, resp_data, resp_ovf, busy.
- States:
  - IDLE: grant = the requester that is valid. If both are valid, grant = !last_grant. req_ready of the granted requester = 1; all other readies = 0. No readies outside IDLE.
  - Accept (valid & ready at an edge): a<=0, b<=1, cnt<=n, ovf_a<=0, ovf_b<=0, owner<=grant.
    - n==0: next state RESP.
    - otherwise: next state RUN.
  - RUN, every cycle:
    - a<=b; b<=(a+b) mod 2^WIDTH; cnt<=cnt-1.
    - ovf_a<=ovf_b; ovf_b<=ovf_a | ovf_b | carry_out(a+b).
    - When cnt==1, next state RESP.
  - RESP:
    - resp{owner}_valid=1; resp_data=a; resp_ovf=ovf_a.
    - Outputs held stable until resp{owner}_ready=1 at an edge.
    - On that edge: state=IDLE, last_grant<=owner.
    - The other requester's resp_ready is ignored.
- Latency: resp_valid rises n edges after the accepting edge (n=0: right after the accepting edge). Total occupancy is n cycles + response wait + at least 1 IDLE cycle. Requests are never accepted back-to-back with a response.
- Invariant: after k RUN steps, a=F(k) and b=F(k+1) mod 2^WIDTH. ovf_a/ovf_b track true overflow of a/b, so an overflow of b alone never flags a.
- req*_n is sampled only at the accepting edge. Changes while RUN have no effect.
- req*_valid may drop without acceptance; no protocol error is flagged.
- Arbitration fairness: with both requesters continuously valid, grants alternate 0,1,0,1,…
- cnt never wraps: RUN exits at cnt==1, and n==0 bypasses RUN. Max n = 2^CNT_W-1 is legal.

Test Plan:
- Single job: req0 n=10, resp0_ready=1 → resp0_valid 10 edges after accept; resp_data=55, ovf=0; then busy=0 for ≥1 cycle.
- Boundary counts:
  - n=0 → data=0, valid one edge after accept.
  - n=1 → data=1.
  - n=13 → data=233, ovf=0.
  - n=14 → data=121, ovf=1.
  - n=255 → ovf=1, no cnt wrap, exactly 255 RUN cycles.
- Simultaneous: req0 and req1 both valid from reset with n=5 and n=6 → req0 served first (data=5), then req1 (data=8), then req0 again if re-presented. Ready is never given to both in one cycle.
- Backpressure: job n=7, resp0_ready low for 5 cycles → resp0_valid, resp_data=13 and ovf held stable; no new request accepted; IDLE one cycle after resp0_ready.
- Wrong-owner ready: owner=1 in RESP with resp0_ready=1, resp1_ready=0 → stays in RESP; resp1_valid stays 1.
- Reset mid-RUN: assert rst 3 cycles into an n=10 job → outputs 0 immediately, no response. After release, a new req1 n=4 with req0 valid → req0 granted first; a fresh job n=4 returns 3.
